// File: rtl/alu_result_display_pkg.sv
// Shared constants for the ALU result display: digit/history geometry and seven-segment glyphs.
// No logic of its own; the helper function is purely combinational.
// Glyphs are active low in {g,f,e,d,c,b,a} order.
package alu_display_pkg;

   localparam int NUM_DIGITS = 8;
   localparam int HIST_DEPTH = 4;

   localparam logic [6:0] SEG_BLANK = 7'h7F;

   localparam logic [6:0] GLYPH_0 = 7'b1000000;
   localparam logic [6:0] GLYPH_1 = 7'b1111001;
   localparam logic [6:0] GLYPH_2 = 7'b0100100;
   localparam logic [6:0] GLYPH_3 = 7'b0110000;
   localparam logic [6:0] GLYPH_4 = 7'b0011001;
   localparam logic [6:0] GLYPH_5 = 7'b0010010;
   localparam logic [6:0] GLYPH_6 = 7'b0000010;
   localparam logic [6:0] GLYPH_7 = 7'b1111000;
   localparam logic [6:0] GLYPH_8 = 7'b0000000;
   localparam logic [6:0] GLYPH_9 = 7'b0010000;
   localparam logic [6:0] GLYPH_A = 7'b0001000;
   localparam logic [6:0] GLYPH_B = 7'b0000011;
   localparam logic [6:0] GLYPH_C = 7'b1000110;
   localparam logic [6:0] GLYPH_D = 7'b0100001;
   localparam logic [6:0] GLYPH_E = 7'b0000110;
   localparam logic [6:0] GLYPH_F = 7'b0001110;

   // Index of the most significant nonzero nibble; 0 when the whole word is zero,
   // so digit 0 is never considered a leading zero.
   function automatic logic [2:0] msd_nibble(input logic [31:0] v);
      logic [2:0] idx;
      idx = 3'd0;
      for (int i = 1; i < NUM_DIGITS; i++) begin
         if (v[4*i +: 4] != 4'h0) idx = 3'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/alu_result_display_if.sv
// Bundles the ALU result sample inputs and the display/debug outputs of the result display.
// No latency; plain wires.
// No backpressure: result_valid is a sample strobe, the consumer never stalls the CPU.
interface alu_result_display_if;
   logic [31:0] result_in;
   logic        result_valid;
   logic        hold;
   logic [1:0]  sel;
   logic [7:0]  an;
   logic [6:0]  seg;
   logic        dp;
   logic [15:0] change_cnt;

   // Master: the CPU/board side that supplies results and controls.
   modport master (
      output result_in, result_valid, hold, sel,
      input  an, seg, dp, change_cnt
   );

   // Slave: the display block itself.
   modport slave (
      input  result_in, result_valid, hold, sel,
      output an, seg, dp, change_cnt
   );
endinterface

// File: rtl/alu_result_display_hex7seg_decoder.sv
// Hex nibble to active-low seven-segment glyph, with a blank override.
// Purely combinational, zero latency.
// No backpressure.
module hex7seg_decoder
   import alu_display_pkg::*;
(
   input  logic [3:0] nibble,
   input  logic       blank,
   output logic [6:0] seg
);

   // Glyph lookup; blank wins over any nibble value.
   always_comb begin
      seg = SEG_BLANK;
      if (!blank) begin
         case (nibble)
            4'h0: seg = GLYPH_0;
            4'h1: seg = GLYPH_1;
            4'h2: seg = GLYPH_2;
            4'h3: seg = GLYPH_3;
            4'h4: seg = GLYPH_4;
            4'h5: seg = GLYPH_5;
            4'h6: seg = GLYPH_6;
            4'h7: seg = GLYPH_7;
            4'h8: seg = GLYPH_8;
            4'h9: seg = GLYPH_9;
            4'hA: seg = GLYPH_A;
            4'hB: seg = GLYPH_B;
            4'hC: seg = GLYPH_C;
            4'hD: seg = GLYPH_D;
            4'hE: seg = GLYPH_E;
            default: seg = GLYPH_F;
         endcase
      end
   end

endmodule

// File: rtl/alu_result_display.sv
// Captures distinct ALU results into a 4-deep history and scans one entry in hex on an 8-digit display.
// Capture 1 cycle; display outputs registered, updated 1 cycle after each prescaler tick.
// No backpressure; optional leading-zero blanking with ALU_DISPLAY_BLANK_LEADING_ZERO_EN.
module alu_result_display
   import alu_display_pkg::*;
#(
   parameter logic [15:0] SCAN_DIV = 16'd50000,
   parameter int          CNT_W    = 16
) (
   input  logic              clk,
   input  logic              rst,
   alu_result_display_if.slave bus
);

   localparam logic [CNT_W-1:0] PRE_MAX = CNT_W'(SCAN_DIV - 16'd1);

   logic [31:0]      hist [HIST_DEPTH];
   logic [15:0]      cnt;
   logic [31:0]      disp_reg;
   logic [CNT_W-1:0] pre;
   logic [2:0]       digit;
   logic [7:0]       an_q;
   logic [6:0]       seg_q;
   logic             dp_q;

   logic             capture;
   logic             tick;
   logic             wrap;
   logic [2:0]       digit_next;
   logic [31:0]      disp_next;
   logic [3:0]       nibble;
   logic             blank;
   logic [6:0]       seg_next;

   // Duplicate results are suppressed so the history only records changes.
   assign capture    = bus.result_valid && !bus.hold && (bus.result_in != hist[0]);
   assign tick       = (pre == PRE_MAX);
   assign wrap       = tick && (digit == 3'd7);
   assign digit_next = tick ? digit + 3'd1 : digit;
   // Frame-boundary load keeps a whole frame on one value; the entry is read before
   // any same-cycle capture shifts the history.
   assign disp_next  = wrap ? hist[bus.sel] : disp_reg;
   assign nibble     = disp_next[{digit_next, 2'b00} +: 4];

`ifdef ALU_DISPLAY_BLANK_LEADING_ZERO_EN
   assign blank = (digit_next > msd_nibble(disp_next));
`else
   assign blank = 1'b0;
`endif

   hex7seg_decoder u_dec (
      .nibble (nibble),
      .blank  (blank),
      .seg    (seg_next)
   );

   // History shift register and saturating change counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < HIST_DEPTH; i++) hist[i] <= 32'h0;
         cnt <= 16'h0;
      end else if (capture) begin
         hist[0] <= bus.result_in;
         for (int i = HIST_DEPTH - 1; i > 0; i--) hist[i] <= hist[i-1];
         if (cnt != 16'hFFFF) cnt <= cnt + 16'd1;
      end
   end

   // Prescaler that sets the per-digit dwell time.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)       pre <= '0;
      else if (tick) pre <= '0;
      else           pre <= pre + CNT_W'(1);
   end

   // Digit scan position and the frame snapshot of the selected history entry.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         digit    <= 3'd0;
         disp_reg <= 32'h0;
      end else begin
         digit    <= digit_next;
         disp_reg <= disp_next;
      end
   end

   // Registered display drive, refreshed only when the digit advances.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         an_q  <= 8'hFE;
         seg_q <= GLYPH_0;
         dp_q  <= 1'b1;
      end else if (tick) begin
         an_q  <= ~(8'b1 << digit_next);
         seg_q <= seg_next;
         dp_q  <= ~((digit_next == 3'd0) && bus.hold);
      end
   end

   assign bus.an         = an_q;
   assign bus.seg        = seg_q;
   assign bus.dp         = dp_q;
   assign bus.change_cnt = cnt;

endmodule

// File: tb/tb_alu_result_display.sv
// Directed, table-driven check of alu_result_display with SCAN_DIV=2.
// Each digit slot lasts exactly 2 cycles; outputs are sampled on the falling edge.
// Expected glyphs come from the bench's own glyph table and hand-written masks.
module tb_alu_result_display;

   logic clk = 1'b0;
   logic rst;
   int   n_chk  = 0;
   int   n_pass = 0;

   logic [6:0] glyph [16];

`ifdef ALU_DISPLAY_BLANK_LEADING_ZERO_EN
   localparam bit BLANK_EN = 1'b1;
`else
   localparam bit BLANK_EN = 1'b0;
`endif

   typedef struct {
      logic [31:0] val;
      logic [7:0]  mask;
      logic [15:0] cnt;
   } vec_t;

   vec_t tv [6];

   alu_result_display_if bus ();

   alu_result_display #(.SCAN_DIV(16'd2), .CNT_W(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   task automatic wait_an(input logic [7:0] v, input string tag);
      int n;
      n = 0;
      while (bus.an === v && n < 40) begin @(negedge clk); n++; end
      while (bus.an !== v && n < 80) begin @(negedge clk); n++; end
      if (bus.an !== v) begin
         n_chk++;
         $display("FAIL %s wait: an=%h never reached %h", tag, bus.an, v);
      end
   endtask

   function automatic logic [6:0] exp_seg(input logic [31:0] v, input logic [7:0] mask, input int d);
      logic [3:0] nib;
      nib = v[4*d +: 4];
      return mask[d] ? 7'h7F : glyph[nib];
   endfunction

   // Align on a fresh frame start, then check every slot's anode, glyph and dp.
   task automatic check_frame(input string tag, input logic [31:0] v, input logic [7:0] mask,
                              input logic [7:0] dps_exp);
      logic [7:0] dps;
      logic [7:0] an_exp;
      wait_an(8'h7F, tag);
      wait_an(8'hFE, tag);
      for (int d = 0; d < 8; d++) begin
         an_exp = ~(8'b1 << d);
         check($sformatf("%s an d%0d", tag, d), bus.an, an_exp);
         check($sformatf("%s seg d%0d", tag, d), bus.seg, exp_seg(v, mask, d));
         dps[d] = bus.dp;
         @(negedge clk);
         @(negedge clk);
      end
      check($sformatf("%s dp", tag), dps, dps_exp);
   endtask

   initial begin
      logic [31:0] seq3 [6];
      glyph = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
      tv[0] = '{32'h12345678, 8'h00, 16'd1};
      tv[1] = '{32'h000000A0, 8'hFC, 16'd2};
      tv[2] = '{32'h0000BEEF, 8'hF0, 16'd3};
      tv[3] = '{32'h80000001, 8'h00, 16'd4};
      tv[4] = '{32'h00000000, 8'hFE, 16'd5};
      tv[5] = '{32'hFEDCBA98, 8'h00, 16'd6};
      seq3  = '{32'h5, 32'h5, 32'h5, 32'h9, 32'h9, 32'hA};

      rst = 1'b1;
      bus.result_in    = 32'h0;
      bus.result_valid = 1'b0;
      bus.hold         = 1'b0;
      bus.sel          = 2'd0;
      repeat (2) @(negedge clk);
      check("reset an", bus.an, 8'hFE);
      check("reset seg", bus.seg, 7'b1000000);
      check("reset dp", bus.dp, 1'b1);
      check("reset cnt", bus.change_cnt, 16'h0);
      rst = 1'b0;

      // Cleared history and snapshot display all zeros.
      check_frame("zero", 32'h0, BLANK_EN ? 8'hFE : 8'h00, 8'hFF);

      // Table: each row captures one new value and shows it on sel=0.
      for (int i = 0; i < 6; i++) begin
         bus.result_in    = tv[i].val;
         bus.result_valid = 1'b1;
         @(negedge clk);
         bus.result_valid = 1'b0;
         check($sformatf("row%0d cnt", i), bus.change_cnt, tv[i].cnt);
         check_frame($sformatf("row%0d", i), tv[i].val, BLANK_EN ? tv[i].mask : 8'h00, 8'hFF);
      end
      // The same value scans again on the following frame.
      check_frame("repeat", tv[5].val, 8'h00, 8'hFF);

      // Reset mid-scan, asserted between clock edges.
      wait_an(8'hF7, "midscan");
      #2 rst = 1'b1;
      #1;
      check("midrst an", bus.an, 8'hFE);
      check("midrst seg", bus.seg, 7'b1000000);
      check("midrst dp", bus.dp, 1'b1);
      check("midrst cnt", bus.change_cnt, 16'h0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      // Duplicate suppression and history selection.
      bus.result_valid = 1'b1;
      for (int i = 0; i < 6; i++) begin
         bus.result_in = seq3[i];
         @(negedge clk);
      end
      bus.result_valid = 1'b0;
      check("dup cnt", bus.change_cnt, 16'd3);
      check_frame("sel0", 32'hA, BLANK_EN ? 8'hFE : 8'h00, 8'hFF);
      bus.sel = 2'd2;
      check_frame("sel2", 32'h5, BLANK_EN ? 8'hFE : 8'h00, 8'hFF);
      bus.sel = 2'd1;
      check_frame("sel1", 32'h9, BLANK_EN ? 8'hFE : 8'h00, 8'hFF);
      bus.sel = 2'd3;
      check_frame("sel3", 32'h0, BLANK_EN ? 8'hFE : 8'h00, 8'hFF);

      // Capture coinciding with the wrap tick: this frame shows the old entry.
      bus.sel = 2'd0;
      wait_an(8'h7F, "simul");
      @(negedge clk);
      bus.result_in    = 32'hB;
      bus.result_valid = 1'b1;
      @(negedge clk);
      bus.result_valid = 1'b0;
      check("simul an", bus.an, 8'hFE);
      check("simul seg", bus.seg, 7'h08);
      check("simul cnt", bus.change_cnt, 16'd4);
      check_frame("simul next", 32'hB, BLANK_EN ? 8'hFE : 8'h00, 8'hFF);

      // Hold freezes capture and lights dp on digit 0 only.
      bus.hold         = 1'b1;
      bus.result_in    = 32'hDEAD;
      bus.result_valid = 1'b1;
      @(negedge clk);
      bus.result_valid = 1'b0;
      check("hold cnt", bus.change_cnt, 16'd4);
      check_frame("hold", 32'hB, BLANK_EN ? 8'hFE : 8'h00, 8'hFE);
      bus.hold         = 1'b0;
      bus.result_valid = 1'b1;
      @(negedge clk);
      bus.result_valid = 1'b0;
      check("unhold cnt", bus.change_cnt, 16'd5);
      check_frame("unhold", 32'hDEAD, BLANK_EN ? 8'hF0 : 8'h00, 8'hFF);

      // Counter saturation.
      bus.hold = 1'b1;
      @(negedge clk);
      force dut.cnt = 16'hFFFE;
      @(negedge clk);
      release dut.cnt;
      bus.hold = 1'b0;
      check("sat preset", bus.change_cnt, 16'hFFFE);
      bus.result_valid = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         bus.result_in = 32'(i);
         @(negedge clk);
         check($sformatf("sat cnt %0d", i), bus.change_cnt, 16'hFFFF);
      end
      bus.result_valid = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/alu_result_display.md
Name: alu_result_display

Overview:
- Downstream consumer of the single-cycle CPU's 32-bit ALU result.
- Keeps a 4-deep history of distinct result values.
- Drives an 8-digit multiplexed seven-segment display, showing the selected entry in hex.
- Provides a hold/freeze control and a saturating change counter for board-level debug.

Parameters:
- SCAN_DIV, 16'd50000, clock cycles per digit slot; legal range 1..65535.
- CNT_W, 16, prescaler counter width; must satisfy 2^CNT_W > SCAN_DIV-1.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- result_in  in  32  ALU result from CPU datapath.
- result_valid  in  1  sample strobe; tie high for a single-cycle CPU.
- hold  in  1  freezes history capture and change counter.
- sel  in  2  history entry to display; 0 = newest, 3 = oldest.
- an  out  8  digit enables, active low; an[0] is the rightmost (least significant) nibble.
- seg  out  7  segments {g,f,e,d,c,b,a}, active low.
- dp  out  1  decimal point, active low.
- change_cnt  out  16  count of captured distinct values.

Behaviour:
- Reset (async, any time including mid-scan):
  - hist[0..3]=0, disp_reg=0, prescaler=0, digit=0, change_cnt=0.
  - an=8'hFE, seg=7'b1000000 (the '0' glyph), dp=1.
- Capture, per clk:
  - Condition: result_valid && !hold && result_in != hist[0].
  - On capture: hist[3]<=hist[2], hist[2]<=hist[1], hist[1]<=hist[0], hist[0]<=result_in.
  - On capture: change_cnt increments, saturating at 16'hFFFF.
  - Equal value: no shift, no count (duplicate suppression).
  - Because hist resets to 0, a first value of 0 is not captured.
- Prescaler:
  - Counts 0..SCAN_DIV-1 and wraps to 0.
  - tick is asserted on the cycle the count equals SCAN_DIV-1.
  - SCAN_DIV=1 gives tick every cycle.
- Digit scan:
  - On tick, digit advances 0→1→…→7→0.
  - On the tick where digit wraps 7→0, disp_reg <= hist[sel]. This prevents tearing; a sel change becomes visible at the next frame boundary only.
- Outputs are registered and updated in the same cycle as the digit advance (1 cycle after tick):
  - an = ~(8'b1 << digit_next).
  - seg = hex glyph of disp_reg[4*digit_next +: 4]; on the wrap tick, use the newly loaded disp_reg value.
  - dp = 0 only when digit_next==0 and hold==1; otherwise 1.
- Glyphs, active low:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
  - blank=1111111.
- Simultaneous events:
  - A capture and a wrap tick in the same cycle: disp_reg takes the pre-capture hist[sel]; the new value appears next frame.
  - hold has no effect on scanning.

Optional Feature:
- Macro: ALU_DISPLAY_BLANK_LEADING_ZERO_EN.
- Defined:
  - Digits above the most significant nonzero nibble of disp_reg show blank (7'b1111111).
  - Digit 0 is always shown, so value 0 displays a single '0'.
  - The blank decision uses the same disp_reg as the glyph.
- Undefined: all 8 digits always show their hex glyph.

Decomposition:
- Shared package (alu_display_pkg):
  - NUM_DIGITS=8, HIST_DEPTH=4.
  - SEG_BLANK=7'h7F.
  - The 16 glyph constants.
- One sub-module: hex7seg_decoder.
  - Combinational: 4-bit nibble + blank flag in, 7-bit active-low seg out.
  - Instantiated once, on the digit_next nibble.

Test Plan:
1. Assert rst for 3 cycles mid-scan, then release → an=8'hFE, seg=7'b1000000, dp=1, change_cnt=0 immediately on assertion.
2. SCAN_DIV=2, sel=0; drive result_in=32'h12345678 one cycle → after the next frame wrap, digits 0..7 show 8,7,6,5,4,3,2,1. an steps FE,FD,FB,…,7F every 2 cycles, then repeats.
3. Drive 5, 5, 5, 9, 9, 0xA with result_valid=1 → change_cnt=3, hist={A,9,5,0}. sel=2 shows 00000005 after the frame wrap.
4. hold=1, drive 0xDEAD → no capture, change_cnt unchanged, dp=0 only while an=8'hFE. hold=0 → capture on the next cycle.
5. Force change_cnt near saturation (0xFFFE) and drive 3 distinct values → change_cnt stops at 16'hFFFF.
6. With ALU_DISPLAY_BLANK_LEADING_ZERO_EN and value 32'h000000A0 → digits 2..7 blank, digit1='A', digit0='0'. With the macro undefined → all digits lit (000000A0).
